// File: rtl/weight_fetch_biu_pkg.sv
// Shared definitions for the weight-fetch bus interface unit:
// kernel-mode encodings, FSM states and bus word geometry.
package acc_pkg;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_K3   = 2'b01;
    localparam logic [1:0] MODE_K1   = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam int WORD_BYTES = 4;
    localparam int OFF_W      = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE3,
        ST_ISSUE1,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/weight_fetch_biu_if.sv
// Read-request / read-response channel between the weight fetcher (master)
// and the bus arbiter (slave).
interface weight_fetch_biu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] req_addr;
    logic              req_vld;
    logic              req_rdy;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_vld;
    logic              rsp_rdy;

    modport master (
        output req_addr, req_vld, rsp_rdy,
        input  req_rdy, rsp_data, rsp_vld
    );

    modport slave (
        input  req_addr, req_vld, rsp_rdy,
        output req_rdy, rsp_data, rsp_vld
    );
endinterface

// File: rtl/weight_fetch_biu_tag_counter.sv
// Nested word-offset / channel / kernel-type counter. Walks the 3x3 words of
// every channel, then (when both kernels are fetched) the 1x1 words.
module wfb_tag_counter
    import acc_pkg::*;
#(
    parameter int K3_WORDS = 72,
    parameter int K1_WORDS = 8,
    parameter int CH_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             clear_k1,
    input  logic             adv,
    input  logic             both,
    input  logic [CH_W-1:0]  ch_num,
    output logic             k1,
    output logic [CH_W-1:0]  ch,
    output logic [OFF_W-1:0] off
);

    localparam logic [OFF_W-1:0] K3_LAST = OFF_W'(K3_WORDS - 1);
    localparam logic [OFF_W-1:0] K1_LAST = OFF_W'(K1_WORDS - 1);

    logic off_last;
    logic ch_last;

    assign off_last = (off == (k1 ? K1_LAST : K3_LAST));
    assign ch_last  = (ch == ch_num - CH_W'(1));

    // Once the final word of the final kernel is passed the counter wraps back
    // to channel 0 of the same kernel, which the top uses for its totals check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k1  <= 1'b0;
            ch  <= '0;
            off <= '0;
        end else if (clear) begin
            k1  <= clear_k1;
            ch  <= '0;
            off <= '0;
        end else if (adv) begin
            if (off_last) begin
                off <= '0;
                if (ch_last) begin
                    ch <= '0;
                    if (!k1 && both)
                        k1 <= 1'b1;
                end else begin
                    ch <= ch + CH_W'(1);
                end
            end else begin
                off <= off + OFF_W'(1);
            end
        end
    end

endmodule

// File: rtl/weight_fetch_biu.sv
// Weight bus interface unit: issues kernel-weight reads for a run of output
// channels with bounded outstanding reads and tags each returned word.
module weight_fetch_biu
    import acc_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int K3_WORDS = 72,
    parameter int K1_WORDS = 8,
    parameter int CH_W     = 8,
    parameter int MAX_OST  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [ADDR_W-1:0]    w3_base,
    input  logic [ADDR_W-1:0]    w1_base,
    input  logic [CH_W-1:0]      ch_first,
    input  logic [CH_W-1:0]      ch_num,
    output logic                 busy,
    output logic                 done,
    weight_fetch_biu_if.master   bus,
    output logic                 wr_en,
    output logic                 wr_k1,
    output logic [CH_W-1:0]      wr_ch,
    output logic [OFF_W-1:0]     wr_off,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 err
);

    localparam int OST_W = $clog2(MAX_OST + 1);
    localparam logic [OST_W-1:0]  OST_MAX   = OST_W'(MAX_OST);
    localparam logic [OFF_W-1:0]  K3_LAST   = OFF_W'(K3_WORDS - 1);
    localparam logic [OFF_W-1:0]  K1_LAST   = OFF_W'(K1_WORDS - 1);
    localparam logic [ADDR_W-1:0] K3_STRIDE = ADDR_W'(K3_WORDS * WORD_BYTES);
    localparam logic [ADDR_W-1:0] K1_STRIDE = ADDR_W'(K1_WORDS * WORD_BYTES);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);

    state_t              state_q, state_d;
    logic                done_d;
    logic [1:0]          mode_q;
    logic [CH_W-1:0]     ch_num_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   a1_q;
    logic [ADDR_W-1:0]   a3_start;
    logic [ADDR_W-1:0]   a1_start;
    logic [OST_W-1:0]    ost_q;

    logic                start_ok, empty, issuing, hs, rsp_ok, err_hit;
    logic                both;
    logic                iss_k1, iss_phase_last, tags_match;
    logic [CH_W-1:0]     iss_ch;
    logic [OFF_W-1:0]    iss_off;

    assign start_ok = start && (state_q == ST_IDLE);
    assign empty    = (mode == MODE_NONE) || (ch_num == '0);
    assign issuing  = (state_q == ST_ISSUE3) || (state_q == ST_ISSUE1);
    assign both     = (mode_q == MODE_BOTH);

    assign bus.req_vld  = issuing && (ost_q < OST_MAX);
    assign bus.req_addr = addr_q;
    assign bus.rsp_rdy  = 1'b1;
    assign hs           = bus.req_vld && bus.req_rdy;
    assign rsp_ok       = bus.rsp_vld && (ost_q != '0);
    assign err_hit      = bus.rsp_vld && (ost_q == '0);

    assign busy    = (state_q != ST_IDLE);
    assign wr_en   = rsp_ok;
    assign wr_data = bus.rsp_data;

    assign a3_start = w3_base + ADDR_W'(ch_first) * K3_STRIDE;
    assign a1_start = w1_base + ADDR_W'(ch_first) * K1_STRIDE;

    assign iss_phase_last = (iss_off == (iss_k1 ? K1_LAST : K3_LAST)) &&
                            (iss_ch == ch_num_q - CH_W'(1));
    // Both counters wrap to the same tag after the final word, so equal tags
    // with nothing in flight means every issued read has been written back.
    assign tags_match = ({wr_k1, wr_ch, wr_off} == {iss_k1, iss_ch, iss_off});

    wfb_tag_counter #(.K3_WORDS(K3_WORDS), .K1_WORDS(K1_WORDS), .CH_W(CH_W)) u_iss_tag (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .clear_k1 (~mode[0]),
        .adv      (hs),
        .both     (both),
        .ch_num   (ch_num_q),
        .k1       (iss_k1),
        .ch       (iss_ch),
        .off      (iss_off)
    );

    wfb_tag_counter #(.K3_WORDS(K3_WORDS), .K1_WORDS(K1_WORDS), .CH_W(CH_W)) u_rsp_tag (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .clear_k1 (~mode[0]),
        .adv      (rsp_ok),
        .both     (both),
        .ch_num   (ch_num_q),
        .k1       (wr_k1),
        .ch       (wr_ch),
        .off      (wr_off)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (empty)
                        done_d = 1'b1;
                    else
                        state_d = mode[0] ? ST_ISSUE3 : ST_ISSUE1;
                end
            end
            ST_ISSUE3: begin
                if (hs && iss_phase_last)
                    state_d = mode_q[1] ? ST_ISSUE1 : ST_DRAIN;
            end
            ST_ISSUE1: begin
                if (hs && iss_phase_last)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((ost_q == '0) && tags_match) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
        end
    end

    // The 1x1 start address is precomputed so the 3x3->1x1 switch needs no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_NONE;
            ch_num_q <= '0;
            addr_q   <= '0;
            a1_q     <= '0;
        end else if (start_ok && !empty) begin
            mode_q   <= mode;
            ch_num_q <= ch_num;
            addr_q   <= mode[0] ? a3_start : a1_start;
            a1_q     <= a1_start;
        end else if (hs) begin
            if ((state_q == ST_ISSUE3) && iss_phase_last && mode_q[1])
                addr_q <= a1_q;
            else
                addr_q <= addr_q + WORD_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ost_q <= '0;
        end else begin
            case ({hs, rsp_ok})
                2'b10:   ost_q <= ost_q + OST_W'(1);
                2'b01:   ost_q <= ost_q - OST_W'(1);
                default: ost_q <= ost_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (err_hit)
            err <= 1'b1;
        else if (start_ok)
            err <= 1'b0;
    end

endmodule

// File: tb/tb_weight_fetch_biu.sv
// Directed self-checking bench for weight_fetch_biu with a behavioural arbiter
// that returns data in issue order.
module tb_weight_fetch_biu;
    import acc_pkg::*;

    typedef struct {
        logic        k1;
        logic [7:0]  ch;
        logic [6:0]  off;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] w3_base = '0;
    logic [31:0] w1_base = '0;
    logic [7:0]  ch_first = '0;
    logic [7:0]  ch_num = '0;
    logic        busy, done, wr_en, wr_k1, err;
    logic [7:0]  wr_ch;
    logic [6:0]  wr_off;
    logic [31:0] wr_data;

    logic [31:0] issued_q[$];
    wr_t         wr_q[$];
    int          done_cnt = 0;
    int          rsp_idx = 0;
    int          force_req = 0;
    int          force_done = 0;
    logic        auto_rsp = 1'b1;
    int          n_cmp = 0;
    int          n_fail = 0;

    weight_fetch_biu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    weight_fetch_biu dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .w3_base  (w3_base),
        .w1_base  (w1_base),
        .ch_first (ch_first),
        .ch_num   (ch_num),
        .busy     (busy),
        .done     (done),
        .bus      (bus),
        .wr_en    (wr_en),
        .wr_k1    (wr_k1),
        .wr_ch    (wr_ch),
        .wr_off   (wr_off),
        .wr_data  (wr_data),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    // Log handshakes and writes mid-cycle, when DUT outputs are settled.
    always @(negedge clk) begin
        if (bus.req_vld && bus.req_rdy && !rst)
            issued_q.push_back(bus.req_addr);
        if (wr_en)
            wr_q.push_back('{wr_k1, wr_ch, wr_off, wr_data});
        if (done)
            done_cnt++;
    end

    // Arbiter model: answers each handshake one cycle later, or on demand when held.
    initial begin
        bus.rsp_vld  = 1'b0;
        bus.rsp_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (auto_rsp && rsp_idx < issued_q.size()) begin
                bus.rsp_vld  = 1'b1;
                bus.rsp_data = pat(issued_q[rsp_idx]);
                rsp_idx++;
            end else if (force_done < force_req) begin
                bus.rsp_vld  = 1'b1;
                bus.rsp_data = (rsp_idx < issued_q.size()) ? pat(issued_q[rsp_idx]) : 32'hDEAD_BEEF;
                if (rsp_idx < issued_q.size())
                    rsp_idx++;
                force_done++;
            end else begin
                bus.rsp_vld = 1'b0;
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] m, input logic [31:0] b3, input logic [31:0] b1,
                                  input logic [7:0] cf, input logic [7:0] cn);
        @(posedge clk);
        #1;
        mode = m; w3_base = b3; w1_base = b1; ch_first = cf; ch_num = cn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int dc0, input int budget, input string tag);
        int n = 0;
        while (done_cnt == dc0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 64'(done_cnt - dc0), 64'd1);
    endtask

    function automatic int seq_errs(input int b, input int n, input logic [31:0] a0);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (b + i >= issued_q.size() || issued_q[b + i] !== a0 + 32'(4 * i))
                e++;
        return e;
    endfunction

    function automatic int data_errs(input int b, input int wb, input int n);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (wb + i >= wr_q.size() || b + i >= issued_q.size() ||
                wr_q[wb + i].data !== pat(issued_q[b + i]))
                e++;
        return e;
    endfunction

    initial begin
        int b, wb, dc, k, bad, m;
        logic [31:0] a0;
        logic        t1_tag_ok;

        bus.req_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_req_vld", bus.req_vld, 0);
        check_output("rst_req_addr", bus.req_addr, 0);
        check_output("rst_wr_en", wr_en, 0);
        check_output("rst_err", err, 0);

        $display("[TB] step 1: mode=11 single channel");
        bus.req_rdy = 1'b1;
        b = issued_q.size(); wb = wr_q.size(); dc = done_cnt;
        apply_stimulus(MODE_BOTH, 32'h1000, 32'h8000, 8'd2, 8'd1);
        wait_done(dc, 400, "t1_done");
        repeat (5) @(negedge clk);
        check_output("t1_done_once", 64'(done_cnt - dc), 64'd1);
        check_output("t1_issue_cnt", 64'(issued_q.size() - b), 64'd80);
        check_output("t1_first_addr", issued_q[b], 64'h1240);
        check_output("t1_k3_seq", 64'(seq_errs(b, 72, 32'h1240)), 64'd0);
        check_output("t1_k1_seq", 64'(seq_errs(b + 72, 8, 32'h8040)), 64'd0);
        check_output("t1_wr_cnt", 64'(wr_q.size() - wb), 64'd80);
        t1_tag_ok = (wr_q[wb].k1 === 1'b0) && (wr_q[wb + 71].off === 7'd71) &&
                    (wr_q[wb + 72].k1 === 1'b1) && (wr_q[wb + 72].off === 7'd0) &&
                    (wr_q[wb + 79].off === 7'd7) && (wr_q[wb + 79].ch === 8'd0);
        check_output("t1_wr_tags", t1_tag_ok, 1'b1);
        check_output("t1_wr_data", 64'(data_errs(b, wb, 80)), 64'd0);
        check_output("t1_busy_after", busy, 0);

        $display("[TB] step 2: req_rdy stall mid 3x3 issue");
        b = issued_q.size(); dc = done_cnt;
        apply_stimulus(MODE_K3, 32'h2000, 32'h0, 8'd0, 8'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 bus.req_rdy = 1'b0;
        @(negedge clk);
        a0 = bus.req_addr;
        k = issued_q.size() - b;
        check_output("t2_stall_addr", a0, 64'(32'h2000 + 32'(4 * k)));
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.req_addr !== a0 || bus.req_vld !== 1'b1)
                bad++;
        end
        check_output("t2_stall_stable", 64'(bad), 64'd0);
        check_output("t2_stall_no_issue", 64'(issued_q.size() - b), 64'(k));
        @(posedge clk);
        #1 bus.req_rdy = 1'b1;
        wait_done(dc, 400, "t2_done");
        check_output("t2_issue_cnt", 64'(issued_q.size() - b), 64'd72);
        check_output("t2_seq", 64'(seq_errs(b, 72, 32'h2000)), 64'd0);

        $display("[TB] step 3: outstanding limit");
        b = issued_q.size(); wb = wr_q.size(); dc = done_cnt;
        auto_rsp = 1'b0;
        apply_stimulus(MODE_K1, 32'h0, 32'h3000, 8'd0, 8'd1);
        repeat (8) @(negedge clk);
        check_output("t3_issue_cap", 64'(issued_q.size() - b), 64'd4);
        check_output("t3_vld_low", bus.req_vld, 0);
        force_req++;
        repeat (5) @(negedge clk);
        check_output("t3_one_more", 64'(issued_q.size() - b), 64'd5);
        check_output("t3_vld_low_again", bus.req_vld, 0);
        auto_rsp = 1'b1;
        wait_done(dc, 100, "t3_done");
        check_output("t3_seq", 64'(seq_errs(b, 8, 32'h3000)), 64'd0);
        check_output("t3_wr_cnt", 64'(wr_q.size() - wb), 64'd8);
        check_output("t3_err", err, 0);

        $display("[TB] step 4: mode=01 three channels");
        b = issued_q.size(); wb = wr_q.size(); dc = done_cnt;
        apply_stimulus(MODE_K3, 32'h0, 32'h0, 8'd1, 8'd3);
        wait_done(dc, 800, "t4_done");
        check_output("t4_issue_cnt", 64'(issued_q.size() - b), 64'd216);
        check_output("t4_seq", 64'(seq_errs(b, 216, 32'h120)), 64'd0);
        check_output("t4_wr_cnt", 64'(wr_q.size() - wb), 64'd216);
        bad = 0;
        for (int i = 0; i < 216; i++)
            if (wb + i >= wr_q.size() || wr_q[wb + i].k1 !== 1'b0 ||
                wr_q[wb + i].ch !== 8'(i / 72) || wr_q[wb + i].off !== 7'(i % 72))
                bad++;
        check_output("t4_wr_tags", 64'(bad), 64'd0);
        check_output("t4_wr_data", 64'(data_errs(b, wb, 216)), 64'd0);

        $display("[TB] step 5: empty start and start while busy");
        b = issued_q.size(); dc = done_cnt;
        apply_stimulus(MODE_BOTH, 32'h1000, 32'h8000, 8'd0, 8'd0);
        @(negedge clk);
        check_output("t5_empty_done", done, 1);
        check_output("t5_empty_busy", busy, 0);
        check_output("t5_empty_vld", bus.req_vld, 0);
        @(negedge clk);
        check_output("t5_empty_done_clr", done, 0);
        check_output("t5_empty_no_issue", 64'(issued_q.size() - b), 64'd0);
        bus.req_rdy = 1'b0;
        dc = done_cnt;
        apply_stimulus(MODE_K1, 32'h0, 32'h4000, 8'd0, 8'd1);
        apply_stimulus(MODE_K3, 32'h9000, 32'h0, 8'd0, 8'd5);
        @(posedge clk);
        #1 bus.req_rdy = 1'b1;
        wait_done(dc, 100, "t5_done");
        repeat (20) @(negedge clk);
        check_output("t5_issue_cnt", 64'(issued_q.size() - b), 64'd8);
        check_output("t5_seq", 64'(seq_errs(b, 8, 32'h4000)), 64'd0);
        check_output("t5_busy_after", busy, 0);

        $display("[TB] step 6: reset mid 1x1 issue");
        b = issued_q.size(); dc = done_cnt;
        apply_stimulus(MODE_BOTH, 32'h5000, 32'h6000, 8'd0, 8'd1);
        k = 0;
        while (issued_q.size() - b < 73 && k < 300) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        auto_rsp = 1'b0;
        bus.req_rdy = 1'b0;
        repeat (3) @(negedge clk);
        k = 0;
        while (issued_q.size() - rsp_idx < 2 && k < 10) begin
            @(posedge clk);
            #1 bus.req_rdy = 1'b1;
            @(posedge clk);
            #1 bus.req_rdy = 1'b0;
            repeat (2) @(negedge clk);
            k++;
        end
        m = issued_q.size() - b;
        check_output("t6_in_k1_addr", issued_q[issued_q.size() - 1], 64'(32'h6000 + 32'(4 * (m - 73))));
        check_output("t6_pre_vld", bus.req_vld, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("t6_rst_busy", busy, 0);
        check_output("t6_rst_vld", bus.req_vld, 0);
        check_output("t6_rst_addr", bus.req_addr, 0);
        wb = wr_q.size();
        dc = done_cnt;
        force_req += 2;
        repeat (6) @(negedge clk);
        check_output("t6_err", err, 1);
        check_output("t6_no_wr", 64'(wr_q.size() - wb), 64'd0);
        check_output("t6_no_done", 64'(done_cnt - dc), 64'd0);
        check_output("t6_idle", busy, 0);
        auto_rsp = 1'b1;
        apply_stimulus(MODE_NONE, 32'h0, 32'h0, 8'd0, 8'd4);
        @(negedge clk);
        check_output("t6_err_cleared", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
